// File: rtl/calc_input_frontend.sv
// calc_input_frontend
// Input conditioner on the write side of the calculator datapath. Raw board
// buttons and switches become clean command words on a valid/ready handshake.
//
// Ports:
//   clock       system clock, all state on the rising edge
//   reset_n     asynchronous active-low reset (assert async, release sync)
//   Switchs     raw switches: [7:0] operand, [11:8] opcode
//   Enter       raw Enter button (active-high, asynchronous, bouncy)
//   Clear       raw Clear button (active-high, asynchronous, bouncy)
//   ready       consumer takes the word when ready && valid at a clock edge
//   valid       Operand/Operation hold a captured word
//   Operand     captured Switchs[7:0]
//   Operation   captured Switchs[11:8]
//   ClearPulse  one-cycle strobe per debounced Clear press
//   Busy        high whenever the Enter FSM is not idle
//
// Optional feature macro: ENTER_REPEAT_EN
//   When defined, a held Enter re-captures the switches every REPEAT_CYCLES
//   cycles. CNT_W must then be wide enough to hold REPEAT_CYCLES-1.
//   When undefined, no repeat counter exists and a held Enter gives one word.

module calc_input_frontend #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] Switchs,
  input  logic        Enter,
  input  logic        Clear,
  input  logic        ready,
  output logic        valid,
  output logic [7:0]  Operand,
  output logic [3:0]  Operation,
  output logic        ClearPulse,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    OFFER        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        valid_next, clear_pulse_next;
  logic [7:0]  operand_next;
  logic [3:0]  operation_next;

  // An out-of-range parameter set elaborates this named, empty block so the
  // mistake is visible by name in the elaborated hierarchy.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_range_violation
  end

  // Switch bank synchroniser; captures only ever read sw_sync.
  logic [11:0] sw_meta, sw_sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= Switchs;
      sw_sync <= sw_meta;
    end
  end

  // Button conditioning: bit 0 = Enter, bit 1 = Clear.
  logic [1:0] btn_raw, btn_deb, btn_rise;
  assign btn_raw = {Clear, Enter};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             meta, sync, deb, deb_q, rise;
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          meta  <= 1'b0;
          sync  <= 1'b0;
          deb   <= 1'b0;
          deb_q <= 1'b0;
          rise  <= 1'b0;
          cnt   <= '0;
        end else begin
          meta  <= btn_raw[gi];
          sync  <= meta;
          deb_q <= deb;
          // Registered rise: one cycle after deb_q catches up with deb.
          rise  <= deb & ~deb_q;
          if (sync == deb) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb <= sync;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign btn_deb[gi]  = deb;
      assign btn_rise[gi] = rise;
    end
  endgenerate

  logic enter_rise, clear_rise, deb_enter;
  assign enter_rise = btn_rise[0];
  assign clear_rise = btn_rise[1];
  assign deb_enter  = btn_deb[0];

  // rep_fire: a held Enter has been waiting long enough to issue another word.
  logic rep_fire;
`ifdef ENTER_REPEAT_EN
  logic [CNT_W-1:0] rep_cnt;

  assign rep_fire = (state == WAIT_RELEASE) && deb_enter && !clear_rise &&
                    (rep_cnt == CNT_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt <= '0;
    end else if ((state == WAIT_RELEASE) && deb_enter && !clear_rise && !rep_fire) begin
      rep_cnt <= rep_cnt + 1'b1;
    end else begin
      rep_cnt <= '0;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_next       = state;
    valid_next       = valid;
    operand_next     = Operand;
    operation_next   = Operation;
    clear_pulse_next = clear_rise;

    if (clear_rise) begin
      // Clear beats everything: drop any pending word and, if Enter is
      // still held, wait for its release so it cannot fire later.
      valid_next = 1'b0;
      state_next = deb_enter ? WAIT_RELEASE : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enter_rise) begin
            operand_next   = sw_sync[7:0];
            operation_next = sw_sync[11:8];
            valid_next     = 1'b1;
            state_next     = OFFER;
          end
        end
        OFFER: begin
          if (ready) begin
            valid_next = 1'b0;
            state_next = deb_enter ? WAIT_RELEASE : IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (!deb_enter) begin
            state_next = IDLE;
          end else if (rep_fire) begin
            operand_next   = sw_sync[7:0];
            operation_next = sw_sync[11:8];
            valid_next     = 1'b1;
            state_next     = OFFER;
          end
        end
        default: begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid      <= 1'b0;
      Operand    <= '0;
      Operation  <= '0;
      ClearPulse <= 1'b0;
    end else begin
      state      <= state_next;
      valid      <= valid_next;
      Operand    <= operand_next;
      Operation  <= operation_next;
      ClearPulse <= clear_pulse_next;
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: doc/calc_input_frontend.md
Name: calc_input_frontend

Overview:
- Input conditioner on the write side of the calculator datapath: turns raw board buttons and switches into clean, handshaken command words.
- Synchronises and debounces Enter and Clear.
- Captures the switch bank on each debounced Enter press and offers it as an operand plus opcode word on a valid/ready handshake.
- Issues a single-cycle clear strobe on each debounced Clear press.
- Sits between the board pins and the calculator control FSM.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); minimum 2.
- CNT_W, 20, width of each debounce and repeat counter; must hold DEBOUNCE_CYCLES and REPEAT_CYCLES.
- REPEAT_CYCLES, 25000000, hold time before Enter auto-repeats; used only with ENTER_REPEAT_EN.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- Switchs  in  12  raw switches; [7:0] operand, [11:8] opcode
- Enter  in  1  raw Enter button, active-high, asynchronous, bouncy
- Clear  in  1  raw Clear button, active-high, asynchronous, bouncy
- ready  in  1  consumer accepts the word when ready&&valid at a clock edge
- valid  out  1  Operand/Operation hold a captured word
- Operand  out  8  captured Switchs[7:0]
- Operation  out  4  captured Switchs[11:8]
- ClearPulse  out  1  one-cycle strobe per debounced Clear press
- Busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: asynchronous assert, synchronous release. While reset_n=0, every register is 0: valid, Operand, Operation, ClearPulse, Busy, both debounced levels, all counters, all synchroniser flops. FSM state is IDLE.
- Synchronisers: 2-flop synchroniser on Enter, Clear and all 12 switches. Switches are captured from the synchronised copy only.
- Debouncer, per button:
  - The counter increments on every cycle where sync != deb; it clears to 0 on any cycle where sync == deb.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync != deb, deb takes the sync value on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Edge detect: a registered copy of each deb signal. rise = deb && !deb_q.
- Latency: a clean press raised just before edge 0 gives the rise on edge DEBOUNCE_CYCLES+2, and valid (or ClearPulse) is high after edge DEBOUNCE_CYCLES+3.
- Enter FSM states: IDLE, OFFER, WAIT_RELEASE.
  - IDLE, on Enter rise and no Clear rise: capture Operand and Operation, set valid=1, go to OFFER.
  - OFFER: valid stays high. Operand and Operation are frozen even if switches change. On an edge with ready=1, clear valid. Then go to WAIT_RELEASE if deb_enter=1, or to IDLE if deb_enter=0.
  - WAIT_RELEASE: wait for deb_enter=0, then go to IDLE. No new capture happens until release.
  - ready high in IDLE or WAIT_RELEASE has no effect.
- Clear:
  - A Clear rise produces ClearPulse=1 for exactly one cycle, in any state.
  - If valid is pending, Clear cancels it: valid goes to 0 and the word is dropped. The FSM then goes to WAIT_RELEASE if deb_enter=1, else IDLE.
  - Clear rise and Enter rise on the same cycle: Clear wins and no capture occurs. The FSM goes to WAIT_RELEASE so the held Enter does not fire later.
  - Clear held down: only one pulse per press.
- Handshake: valid never drops without an accept or a Clear. Back-to-back words require a release and a new press.
- Busy = (state != IDLE).
- Reset mid-operation: a pending word is lost, valid and ClearPulse drop immediately, and a held Enter after release is treated as a fresh press only once it debounces.

Optional Feature:
- ENTER_REPEAT_EN defined:
  - In WAIT_RELEASE, a repeat counter increments each cycle while deb_enter=1.
  - At REPEAT_CYCLES-1 the block recaptures the switches, sets valid, goes to OFFER and clears the counter.
  - Release or Clear clears the counter.
- ENTER_REPEAT_EN not defined:
  - No repeat counter is built and REPEAT_CYCLES is unused.
  - A held Enter yields exactly one word.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20):
- Reset, then Switchs=12'h3A5 and Enter high from edge 0, ready=0 -> valid=1 after edge 7, Operand=8'hA5, Operation=4'h3. Both hold while Switchs changes to 12'h000.
- Continue the previous case: ready=1 for one cycle -> valid drops on that edge. Enter still held -> Busy=1 and no second word. Release Enter -> Busy=0 about 7 cycles later.
- Enter pulses of 3 cycles high / 3 cycles low, repeated 10 times -> valid never asserts and the debounced level never changes.
- valid pending, Clear held 10 cycles -> ClearPulse high for exactly 1 cycle after edge 7 of Clear, valid=0 on the same edge, FSM returns to IDLE.
- Enter and Clear raised on the same edge -> ClearPulse once, valid stays 0, Busy=1 until Enter is released.
- ENTER_REPEAT_EN defined, Enter held 60 cycles, ready=1 constant -> first word after edge 7, then a repeat word every 21 cycles (2 further words). Without the macro -> exactly 1 word.
